// File: rtl/e203_soc_top.sv
// e203_soc_top: SoC pad shell with a JTAG TAP (oversampled in hfextclk) driving GPIO boundary registers; IDCODE enabled by E203_SOC_JTAG_IDCODE_EN
module e203_soc_top #(
    parameter logic [31:0] IDCODE_VALUE = 32'h1E200A6D
) (
    input  logic        hfextclk,
    input  logic        io_pads_aon_erst_n_i_ival,
    input  logic        lfextclk,
    output logic        hfxoscen,
    output logic        lfxoscen,
    input  logic        io_pads_jtag_TCK_i_ival,
    input  logic        io_pads_jtag_TMS_i_ival,
    input  logic        io_pads_jtag_TDI_i_ival,
    output logic        io_pads_jtag_TDO_o_oval,
    output logic        io_pads_jtag_TDO_o_oe,
    input  logic [31:0] io_pads_gpioA_i_ival,
    output logic [31:0] io_pads_gpioA_o_oval,
    output logic [31:0] io_pads_gpioA_o_oe,
    input  logic [31:0] io_pads_gpioB_i_ival,
    output logic [31:0] io_pads_gpioB_o_oval,
    output logic [31:0] io_pads_gpioB_o_oe,
    output logic        io_pads_qspi0_sck_o_oval,
    output logic        io_pads_qspi0_cs_0_o_oval,
    input  logic        io_pads_qspi0_dq_0_i_ival,
    output logic        io_pads_qspi0_dq_0_o_oval,
    output logic        io_pads_qspi0_dq_0_o_oe,
    input  logic        io_pads_qspi0_dq_1_i_ival,
    output logic        io_pads_qspi0_dq_1_o_oval,
    output logic        io_pads_qspi0_dq_1_o_oe,
    input  logic        io_pads_qspi0_dq_2_i_ival,
    output logic        io_pads_qspi0_dq_2_o_oval,
    output logic        io_pads_qspi0_dq_2_o_oe,
    input  logic        io_pads_qspi0_dq_3_i_ival,
    output logic        io_pads_qspi0_dq_3_o_oval,
    output logic        io_pads_qspi0_dq_3_o_oe,
    input  logic        io_pads_aon_pmu_dwakeup_n_i_ival,
    output logic        io_pads_aon_pmu_vddpaden_o_oval,
    output logic        io_pads_aon_pmu_padrst_o_oval,
    input  logic        io_pads_bootrom_n_i_ival,
    input  logic        io_pads_dbgmode0_n_i_ival,
    input  logic        io_pads_dbgmode1_n_i_ival,
    input  logic        io_pads_dbgmode2_n_i_ival
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

`ifdef E203_SOC_JTAG_IDCODE_EN
    localparam logic [4:0] IR_RST = 5'h01;
`else
    localparam logic [4:0] IR_RST = 5'h1F;
`endif

    logic [1:0]  r_rst_sync;
    logic [4:0]  r_pad_cnt;
    logic [2:0]  r_tck_s;
    logic [1:0]  r_tms_s;
    logic [1:0]  r_tdi_s;
    tap_t        r_state;
    tap_t        w_nxt;
    logic [4:0]  r_ir;
    logic [4:0]  r_ir_sr;
    logic [63:0] r_dr;
    logic [63:0] r_gpio_oval;
    logic [63:0] r_gpio_oe;
    logic        r_tdo;
    logic        r_tdo_oe;
    logic        w_rst_n;
    logic        w_rise;
    logic        w_fall;
    logic        w_tms;
    logic        w_tdi;
    logic        w_is_id;
    logic        w_is_go;
    logic        w_is_gi;
    logic        w_is_ge;
    logic [63:0] w_cap;
    logic [63:0] w_dr_shift;
    logic        w_unused;

    assign w_rst_n = r_rst_sync[1];
    assign w_rise  = r_tck_s[1] & ~r_tck_s[2];
    assign w_fall  = ~r_tck_s[1] & r_tck_s[2];
    assign w_tms   = r_tms_s[1];
    assign w_tdi   = r_tdi_s[1];

`ifdef E203_SOC_JTAG_IDCODE_EN
    assign w_is_id = (r_ir == 5'h01);
`else
    assign w_is_id = 1'b0;
`endif
    assign w_is_go = (r_ir == 5'h10);
    assign w_is_gi = (r_ir == 5'h11);
    assign w_is_ge = (r_ir == 5'h12);

    assign w_cap = w_is_go ? r_gpio_oval :
                   w_is_gi ? {io_pads_gpioB_i_ival, io_pads_gpioA_i_ival} :
                   w_is_ge ? r_gpio_oe :
                   w_is_id ? {32'b0, IDCODE_VALUE} : 64'b0;

    assign w_dr_shift = (w_is_go | w_is_gi | w_is_ge) ? {w_tdi, r_dr[63:1]} :
                        w_is_id ? {32'b0, w_tdi, r_dr[31:1]} : {63'b0, w_tdi};

    assign hfxoscen = 1'b1;
    assign lfxoscen = 1'b1;
    assign io_pads_qspi0_sck_o_oval  = 1'b0;
    assign io_pads_qspi0_cs_0_o_oval = 1'b1;
    assign io_pads_qspi0_dq_0_o_oval = 1'b0;
    assign io_pads_qspi0_dq_0_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_1_o_oval = 1'b0;
    assign io_pads_qspi0_dq_1_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_2_o_oval = 1'b0;
    assign io_pads_qspi0_dq_2_o_oe   = 1'b0;
    assign io_pads_qspi0_dq_3_o_oval = 1'b0;
    assign io_pads_qspi0_dq_3_o_oe   = 1'b0;
    assign io_pads_aon_pmu_vddpaden_o_oval = w_rst_n;
    assign io_pads_aon_pmu_padrst_o_oval   = ~r_pad_cnt[4];
    assign io_pads_jtag_TDO_o_oval = r_tdo;
    assign io_pads_jtag_TDO_o_oe   = r_tdo_oe;
    assign io_pads_gpioA_o_oval = r_gpio_oval[31:0];
    assign io_pads_gpioB_o_oval = r_gpio_oval[63:32];
    assign io_pads_gpioA_o_oe   = r_gpio_oe[31:0];
    assign io_pads_gpioB_o_oe   = r_gpio_oe[63:32];

    assign w_unused = &{1'b0, lfextclk, io_pads_aon_pmu_dwakeup_n_i_ival, io_pads_bootrom_n_i_ival,
                        io_pads_dbgmode0_n_i_ival, io_pads_dbgmode1_n_i_ival, io_pads_dbgmode2_n_i_ival,
                        io_pads_qspi0_dq_0_i_ival, io_pads_qspi0_dq_1_i_ival,
                        io_pads_qspi0_dq_2_i_ival, io_pads_qspi0_dq_3_i_ival};

    // Reset synchronizer: assert immediately with the pin, release after two clocks
    always_ff @(posedge hfextclk or negedge io_pads_aon_erst_n_i_ival) begin
        if (!io_pads_aon_erst_n_i_ival) r_rst_sync <= 2'b00;
        else r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    // Pad reset stays high for 16 clocks after internal reset release
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) r_pad_cnt <= 5'd0;
        else if (!r_pad_cnt[4]) r_pad_cnt <= r_pad_cnt + 5'd1;
    end

    // JTAG pin synchronizers; third TCK flop feeds the edge detector
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tck_s <= 3'b000;
            r_tms_s <= 2'b00;
            r_tdi_s <= 2'b00;
        end else begin
            r_tck_s <= {r_tck_s[1:0], io_pads_jtag_TCK_i_ival};
            r_tms_s <= {r_tms_s[0], io_pads_jtag_TMS_i_ival};
            r_tdi_s <= {r_tdi_s[0], io_pads_jtag_TDI_i_ival};
        end
    end

    // TAP state register
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= TLR;
        else r_state <= w_nxt;
    end

    // TAP next state, advancing only on a TCK rise
    always_comb begin
        w_nxt = r_state;
        if (w_rise) begin
            case (r_state)
                TLR:     w_nxt = w_tms ? TLR    : RTI;
                RTI:     w_nxt = w_tms ? SEL_DR : RTI;
                SEL_DR:  w_nxt = w_tms ? SEL_IR : CAP_DR;
                CAP_DR:  w_nxt = w_tms ? EX1_DR : SH_DR;
                SH_DR:   w_nxt = w_tms ? EX1_DR : SH_DR;
                EX1_DR:  w_nxt = w_tms ? UPD_DR : PA_DR;
                PA_DR:   w_nxt = w_tms ? EX2_DR : PA_DR;
                EX2_DR:  w_nxt = w_tms ? UPD_DR : SH_DR;
                UPD_DR:  w_nxt = w_tms ? SEL_DR : RTI;
                SEL_IR:  w_nxt = w_tms ? TLR    : CAP_IR;
                CAP_IR:  w_nxt = w_tms ? EX1_IR : SH_IR;
                SH_IR:   w_nxt = w_tms ? EX1_IR : SH_IR;
                EX1_IR:  w_nxt = w_tms ? UPD_IR : PA_IR;
                PA_IR:   w_nxt = w_tms ? EX2_IR : PA_IR;
                EX2_IR:  w_nxt = w_tms ? UPD_IR : SH_IR;
                UPD_IR:  w_nxt = w_tms ? SEL_DR : RTI;
                default: w_nxt = TLR;
            endcase
        end
    end

    // Instruction register and its shift stage
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ir    <= IR_RST;
            r_ir_sr <= 5'b0;
        end else if (w_rise) begin
            if (w_nxt == TLR) r_ir <= IR_RST;
            else if (r_state == UPD_IR) r_ir <= r_ir_sr;
            if (r_state == CAP_IR) r_ir_sr <= 5'b00001;
            else if (r_state == SH_IR) r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
        end
    end

    // Shared data-register shift stage, length chosen by the current instruction
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) r_dr <= 64'b0;
        else if (w_rise && r_state == CAP_DR) r_dr <= w_cap;
        else if (w_rise && r_state == SH_DR) r_dr <= w_dr_shift;
    end

    // GPIO output and enable registers, written only from Update-DR
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_gpio_oval <= 64'b0;
            r_gpio_oe   <= 64'b0;
        end else if (w_rise && r_state == UPD_DR) begin
            if (w_is_go) r_gpio_oval <= r_dr;
            if (w_is_ge) r_gpio_oe <= r_dr;
        end
    end

    // TDO launches on the TCK fall, driven only while shifting
    always_ff @(posedge hfextclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else if (w_fall) begin
            r_tdo    <= (r_state == SH_IR) ? r_ir_sr[0] : r_dr[0];
            r_tdo_oe <= (r_state == SH_IR) || (r_state == SH_DR);
        end
    end
endmodule

// File: tb/tb_e203_soc_top.sv
// tb_e203_soc_top: table-driven JTAG bench for e203_soc_top
module tb_e203_soc_top;
    logic        clk = 1'b0;
    logic        rst_n, tck, tms, tdi;
    logic        hfxoscen, lfxoscen, tdo, tdo_oe;
    logic [31:0] ga_i, gb_i, ga_o, ga_oe, gb_o, gb_oe;
    logic        sck, cs, dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe;
    logic        vddpaden, padrst;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [4:0]  ir;
        logic [63:0] din;
        logic [63:0] exp_oval;
        logic [63:0] exp_oe;
        logic [31:0] exp_tdo;
    } vec_t;
    vec_t vecs[7];

`ifdef E203_SOC_JTAG_IDCODE_EN
    localparam logic [31:0] EXP_RST_READ = 32'h1E200A6D;
    localparam logic [31:0] EXP_IR1_READ = 32'h1E200A6D;
`else
    localparam logic [31:0] EXP_RST_READ = 32'h0000_0016;
    localparam logic [31:0] EXP_IR1_READ = 32'h0000_0006;
`endif

    always #5 clk = ~clk;

    e203_soc_top dut (
        .hfextclk(clk), .io_pads_aon_erst_n_i_ival(rst_n), .lfextclk(1'b0),
        .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
        .io_pads_jtag_TCK_i_ival(tck), .io_pads_jtag_TMS_i_ival(tms), .io_pads_jtag_TDI_i_ival(tdi),
        .io_pads_jtag_TDO_o_oval(tdo), .io_pads_jtag_TDO_o_oe(tdo_oe),
        .io_pads_gpioA_i_ival(ga_i), .io_pads_gpioA_o_oval(ga_o), .io_pads_gpioA_o_oe(ga_oe),
        .io_pads_gpioB_i_ival(gb_i), .io_pads_gpioB_o_oval(gb_o), .io_pads_gpioB_o_oe(gb_oe),
        .io_pads_qspi0_sck_o_oval(sck), .io_pads_qspi0_cs_0_o_oval(cs),
        .io_pads_qspi0_dq_0_i_ival(1'b0), .io_pads_qspi0_dq_0_o_oval(dq0_o), .io_pads_qspi0_dq_0_o_oe(dq0_oe),
        .io_pads_qspi0_dq_1_i_ival(1'b0), .io_pads_qspi0_dq_1_o_oval(dq1_o), .io_pads_qspi0_dq_1_o_oe(dq1_oe),
        .io_pads_qspi0_dq_2_i_ival(1'b0), .io_pads_qspi0_dq_2_o_oval(dq2_o), .io_pads_qspi0_dq_2_o_oe(dq2_oe),
        .io_pads_qspi0_dq_3_i_ival(1'b0), .io_pads_qspi0_dq_3_o_oval(dq3_o), .io_pads_qspi0_dq_3_o_oe(dq3_oe),
        .io_pads_aon_pmu_dwakeup_n_i_ival(1'b1),
        .io_pads_aon_pmu_vddpaden_o_oval(vddpaden), .io_pads_aon_pmu_padrst_o_oval(padrst),
        .io_pads_bootrom_n_i_ival(1'b1), .io_pads_dbgmode0_n_i_ival(1'b1),
        .io_pads_dbgmode1_n_i_ival(1'b1), .io_pads_dbgmode2_n_i_ival(1'b1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v);
        tms = tms_v;
        tdi = tdi_v;
        tck = 1'b1;
        repeat (6) @(negedge clk);
        tck = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic tap_reset();
        repeat (5) tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic load_ir(input logic [4:0] code);
        logic [4:0] cap;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cap[i] = tdo;
            tck_cycle(i == 4, code[i]);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        chk("ir_capture", {59'b0, cap}, 64'h1);
    endtask

    task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic oe_ok;
        oe_ok = 1'b1;
        dout = 64'b0;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            if (tdo_oe !== 1'b1) oe_ok = 1'b0;
            tck_cycle(i == n - 1, din[i]);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        chk("dr_oe_shift", {63'b0, oe_ok}, 64'h1);
        chk("dr_oe_idle", {63'b0, tdo_oe}, 64'h0);
    endtask

    initial begin
        logic [63:0] d;
        vecs[0] = '{5'h10, 64'h0000_00FF_A5A5_0001, 64'h0000_00FF_A5A5_0001, 64'h0, 32'h0};
        vecs[1] = '{5'h12, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_00FF_A5A5_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0};
        vecs[2] = '{5'h11, 64'h0, 64'h0000_00FF_A5A5_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1234_5678};
        vecs[3] = '{5'h10, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hA5A5_0001};
        vecs[4] = '{5'h12, 64'h0F0F_0000_0000_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_0000_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{5'h03, 64'hDEAD_0000_C000_0005, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_0000_FFFF, 32'h8000_000A};
        vecs[6] = '{5'h01, 64'h0000_0000_0000_0003, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_0000_FFFF, EXP_IR1_READ};
        rst_n = 1'b0;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        ga_i = 32'h1234_5678;
        gb_i = 32'hCAFE_F00D;
        repeat (5) @(negedge clk);
        chk("rst_padrst", {63'b0, padrst}, 64'h1);
        chk("rst_vddpaden", {63'b0, vddpaden}, 64'h0);
        chk("rst_gpio", {ga_o, gb_o}, 64'h0);
        chk("rst_tdo", {62'b0, tdo, tdo_oe}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("sync_vddpaden", {63'b0, vddpaden}, 64'h0);
        repeat (9) @(negedge clk);
        chk("mid_padrst", {63'b0, padrst}, 64'h1);
        repeat (10) @(negedge clk);
        chk("pad_out", {60'b0, padrst, vddpaden, hfxoscen, lfxoscen}, 64'h7);
        chk("qspi", {54'b0, sck, cs, dq0_o, dq0_oe, dq1_o, dq1_oe, dq2_o, dq2_oe, dq3_o, dq3_oe}, 64'h100);
        chk("tdo_oe_idle", {63'b0, tdo_oe}, 64'h0);
        tck_cycle(1'b0, 1'b0);
        shift_dr(64'hB, 32, d);
        chk("reset_ir_read", d, {32'b0, EXP_RST_READ});
        for (int i = 0; i < 7; i++) begin
            load_ir(vecs[i].ir);
            shift_dr(vecs[i].din, 64, d);
            chk($sformatf("v%0d_tdo", i), {32'b0, d[31:0]}, {32'b0, vecs[i].exp_tdo});
            chk($sformatf("v%0d_oval", i), {gb_o, ga_o}, vecs[i].exp_oval);
            chk($sformatf("v%0d_oe", i), {gb_oe, ga_oe}, vecs[i].exp_oe);
        end
        load_ir(5'h10);
        tap_reset();
        chk("tlr_oval_kept", {gb_o, ga_o}, 64'h1234_5678_9ABC_DEF0);
        chk("tlr_oe_kept", {gb_oe, ga_oe}, 64'h0F0F_0000_0000_FFFF);
        shift_dr(64'hB, 32, d);
        chk("tlr_ir_read", d, {32'b0, EXP_RST_READ});
        load_ir(5'h10);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        repeat (10) tck_cycle(1'b0, 1'b1);
        chk("midshift_oe", {63'b0, tdo_oe}, 64'h1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_oval", {gb_o, ga_o}, 64'h0);
        chk("abort_oe", {gb_oe, ga_oe}, 64'h0);
        chk("abort_pads", {61'b0, tdo_oe, padrst, vddpaden}, 64'h2);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        tck_cycle(1'b0, 1'b0);
        shift_dr(64'hB, 32, d);
        chk("abort_tlr_read", d, {32'b0, EXP_RST_READ});
        chk("abort_gpio_after", {gb_o, ga_o, gb_oe[0], ga_oe[0]}, 66'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
